// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: default pointer geometry and the Gray/binary conversions
// used identically by the read-side and write-side controllers.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

    // Conversions work on a 32-bit container; callers zero-extend in and truncate out.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the clock domain of clk.
// No logic ahead of the first flop; every stage clears on the async active-low reset.
module gray_ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/read_control_logic.sv
// Read-side pointer/flag controller of the dual-clock FIFO: syncs the write Gray pointer, advances the
// read pointer, and registers empty and fill level. Optional almost-empty flag under READ_ALMOST_EMPTY_EN.
module read_control_logic
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int SYNC_STAGES = 2
`ifdef READ_ALMOST_EMPTY_EN
    ,
    parameter int AE_THRESH   = 2
`endif
) (
    input  logic                read_clk,
    input  logic                read_rst_n,
    input  logic                read_enable_in,
    input  logic [ADDR_WIDTH:0] write_addr_gray_async,
    output logic [ADDR_WIDTH:0] read_addr_gray,
    output logic [ADDR_WIDTH:0] read_addr,
    output logic                read_enable_out,
`ifdef READ_ALMOST_EMPTY_EN
    output logic                fifo_almost_empty,
`endif
    output logic                fifo_empty,
    output logic [ADDR_WIDTH:0] fifo_level
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] wgray_s;
    logic [PTR_W-1:0] wbin_s;
    logic [PTR_W-1:0] rptr_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] level_next;
    logic             empty_next;

    gray_ptr_sync #(
        .WIDTH (PTR_W),
        .STAGES(SYNC_STAGES)
    ) u_wptr_sync (
        .clk  (read_clk),
        .rst_n(read_rst_n),
        .d    (write_addr_gray_async),
        .q    (wgray_s)
    );

    // Empty compares the full pointer incl. wrap bit; level is a modular difference against the
    // (stale, hence pessimistic) synchronized write pointer.
    always_comb begin
        read_enable_out = read_enable_in & ~fifo_empty;
        rptr_next       = read_addr + PTR_W'(read_enable_out);
        rgray_next      = PTR_W'(bin2gray(32'(rptr_next)));
        wbin_s          = PTR_W'(gray2bin(32'(wgray_s)));
        level_next      = wbin_s - rptr_next;
        empty_next      = (rgray_next == wgray_s);
    end

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            read_addr      <= '0;
            read_addr_gray <= '0;
            fifo_empty     <= 1'b1;
            fifo_level     <= '0;
        end else begin
            read_addr      <= rptr_next;
            read_addr_gray <= rgray_next;
            fifo_empty     <= empty_next;
            fifo_level     <= level_next;
        end
    end

`ifdef READ_ALMOST_EMPTY_EN
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            fifo_almost_empty <= 1'b1;
        end else begin
            fifo_almost_empty <= (level_next <= PTR_W'(AE_THRESH));
        end
    end
`endif

endmodule
